// File: rtl/ram_dp_if.sv
// Bus bundle for the dual-port RAM: port A (CPU, reads every cycle),
// port B (loader/debug, request/strobe) and the ready flag.
interface ram_dp_if #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int DATA_WIDTH    = 8
);
  logic                     ready;
  logic                     a_we;
  logic [ADDRESS_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0]    a_din;
  logic [DATA_WIDTH-1:0]    a_dout;
  logic                     b_en;
  logic                     b_we;
  logic [ADDRESS_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0]    b_din;
  logic [DATA_WIDTH-1:0]    b_dout;
  logic                     b_valid;

  // Requester side: drives addresses, data and enables.
  modport master (
    input  ready, a_dout, b_dout, b_valid,
    output a_we, a_addr, a_din, b_en, b_we, b_addr, b_din
  );

  // Memory side.
  modport slave (
    output ready, a_dout, b_dout, b_valid,
    input  a_we, a_addr, a_din, b_en, b_we, b_addr, b_din
  );
endinterface

// File: rtl/ram_dp.sv
// Dual-port RAM with read-first ports, optional zero-fill after reset and
// a read latency of 1 or 2 cycles. Port A wins same-address write collisions.
module ram_dp #(
  parameter int ADDRESS_WIDTH  = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int READ_LATENCY   = 1,   // 1 or 2; anything other than 2 builds as 1
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic     clk,
  input logic     rst_n,
  ram_dp_if.slave ram_io
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;
  // Clear counter is one bit wider so reaching DEPTH ends the clear without wrap.
  localparam logic [ADDRESS_WIDTH:0] CLR_END = (ADDRESS_WIDTH + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_RST   = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                   state_q;
  logic [ADDRESS_WIDTH:0]   clr_cnt_q;
  logic [ADDRESS_WIDTH:0]   clr_cnt_d;
  logic                     ready_q;

  logic [DATA_WIDTH-1:0]    mem_q [DEPTH];

  logic                     clr_wr;
  logic                     a_wr;
  logic                     b_wr;
  logic                     b_rd;
  logic                     wa_en;
  logic [ADDRESS_WIDTH-1:0] wa_addr;
  logic [DATA_WIDTH-1:0]    wa_data;

  logic [DATA_WIDTH-1:0]    a_rd_q;
  logic [DATA_WIDTH-1:0]    b_rd_q;
  logic                     b_vld1_q;

  assign clr_cnt_d = clr_cnt_q + 1'b1;

  // The first edge after rst_n rises already clears address 0, so the clear
  // spans exactly DEPTH cycles from release. rst_n gates it so that clock
  // edges while reset is held never touch the array.
  assign clr_wr = CLEAR_ON_RESET && (state_q != ST_RUN) && rst_n;

  // Requests are only honoured once the block is ready.
  assign a_wr = ready_q && ram_io.a_we;
  assign b_wr = ready_q && ram_io.b_en && ram_io.b_we;
  assign b_rd = ready_q && ram_io.b_en && !ram_io.b_we;

  // The clear borrows port A's write path; the two never overlap.
  assign wa_en   = clr_wr || a_wr;
  assign wa_addr = clr_wr ? clr_cnt_q[ADDRESS_WIDTH-1:0] : ram_io.a_addr;
  assign wa_data = clr_wr ? '0 : ram_io.a_din;

  assign ram_io.ready = ready_q;

  // Control FSM: RST -> (CLEAR ->) RUN, with registered ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RST;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RST, ST_CLEAR: begin
          if (CLEAR_ON_RESET) begin
            clr_cnt_q <= clr_cnt_d;
            if (clr_cnt_d == CLR_END) begin
              state_q <= ST_RUN;
              ready_q <= 1'b1;
            end else begin
              state_q <= ST_CLEAR;
            end
          end else begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          state_q <= ST_RUN;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= ST_RST;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Array writes. Port A is applied after port B so A's data lands on a
  // same-address collision; B's data is silently dropped.
  always_ff @(posedge clk) begin
    if (b_wr) begin
      mem_q[ram_io.b_addr] <= b_din_w();
    end
    if (wa_en) begin
      mem_q[wa_addr] <= wa_data;
    end
  end

  function automatic logic [DATA_WIDTH-1:0] b_din_w();
    return ram_io.b_din;
  endfunction

  // First read stage: registered, read-first array read on both ports.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_rd_q   <= '0;
      b_rd_q   <= '0;
      b_vld1_q <= 1'b0;
    end else begin
      a_rd_q   <= ready_q ? mem_q[ram_io.a_addr] : '0;
      b_vld1_q <= b_rd;
      if (b_rd) begin
        b_rd_q <= mem_q[ram_io.b_addr];
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic [DATA_WIDTH-1:0] a_out_q;
    logic [DATA_WIDTH-1:0] b_out_q;
    logic                  b_vld2_q;

    // Second read stage: output register after the array register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        a_out_q  <= '0;
        b_out_q  <= '0;
        b_vld2_q <= 1'b0;
      end else begin
        a_out_q  <= a_rd_q;
        b_vld2_q <= b_vld1_q;
        if (b_vld1_q) begin
          b_out_q <= b_rd_q;
        end
      end
    end

    assign ram_io.a_dout  = a_out_q;
    assign ram_io.b_dout  = b_out_q;
    assign ram_io.b_valid = b_vld2_q;
  end else begin : g_lat1
    assign ram_io.a_dout  = a_rd_q;
    assign ram_io.b_dout  = b_rd_q;
    assign ram_io.b_valid = b_vld1_q;
  end

endmodule

// File: tb/tb_ram_dp.sv
// Bench for ram_dp: one instance per read latency, driven with identical
// stimulus and compared cycle by cycle against a behavioural memory model.
`timescale 1ns/1ps
module tb_ram_dp;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  ram_dp_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();
  ram_dp_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

  assign bus2.a_we   = bus1.a_we;
  assign bus2.a_addr = bus1.a_addr;
  assign bus2.a_din  = bus1.a_din;
  assign bus2.b_en   = bus1.b_en;
  assign bus2.b_we   = bus1.b_we;
  assign bus2.b_addr = bus1.b_addr;
  assign bus2.b_din  = bus1.b_din;

  ram_dp #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1))
    dut_l1 (.clk(clk), .rst_n(rst_n), .ram_io(bus1.slave));

  ram_dp #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .CLEAR_ON_RESET(1'b1))
    dut_l2 (.clk(clk), .rst_n(rst_n), .ram_io(bus2.slave));

  // Reference model: memory contents, ready flag and the results of the
  // last two accepted cycles (latency 1 shows the newest, latency 2 the older).
  typedef struct packed {
    logic [DW-1:0] a;
    logic          bv;
    logic [DW-1:0] bd;
  } res_t;

  logic [DW-1:0] mem_m [DEPTH];
  bit            ready_m;
  int            clr_m;
  res_t          h1;
  res_t          h2;
  logic [DW-1:0] bd1_m;
  logic [DW-1:0] bd2_m;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic awe, input logic [AW-1:0] aaddr, input logic [DW-1:0] adin,
                        input logic ben, input logic bwe, input logic [AW-1:0] baddr,
                        input logic [DW-1:0] bdin);
    bus1.a_we   = awe;
    bus1.a_addr = aaddr;
    bus1.a_din  = adin;
    bus1.b_en   = ben;
    bus1.b_we   = bwe;
    bus1.b_addr = baddr;
    bus1.b_din  = bdin;
  endtask

  task automatic idle();
    set_in(1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  // One clock: evaluate the model on the current inputs, clock, then compare.
  task automatic tick();
    res_t r;
    r = '0;
    if (ready_m) begin
      r.a  = mem_m[bus1.a_addr];
      r.bv = bus1.b_en && !bus1.b_we;
      r.bd = mem_m[bus1.b_addr];
      if (bus1.b_en && bus1.b_we) mem_m[bus1.b_addr] = bus1.b_din;
      if (bus1.a_we) mem_m[bus1.a_addr] = bus1.a_din;
    end else begin
      clr_m++;
    end
    @(posedge clk);
    #1;
    if (!ready_m && clr_m == DEPTH) begin
      ready_m = 1'b1;
      foreach (mem_m[i]) mem_m[i] = '0;
    end
    h2 = h1;
    h1 = r;
    if (h1.bv) bd1_m = h1.bd;
    if (h2.bv) bd2_m = h2.bd;
    check("ready_l1",   bus1.ready,   ready_m);
    check("ready_l2",   bus2.ready,   ready_m);
    check("a_dout_l1",  bus1.a_dout,  h1.a);
    check("b_valid_l1", bus1.b_valid, h1.bv);
    check("b_dout_l1",  bus1.b_dout,  bd1_m);
    check("a_dout_l2",  bus2.a_dout,  h2.a);
    check("b_valid_l2", bus2.b_valid, h2.bv);
    check("b_dout_l2",  bus2.b_dout,  bd2_m);
  endtask

  // Assert reset between edges, check the asynchronous clear of outputs,
  // hold for a few edges and release mid-cycle.
  task automatic do_reset(input int hold_cycles);
    rst_n = 1'b0;
    #1;
    check("rst_ready_l1",   bus1.ready,   1'b0);
    check("rst_b_valid_l1", bus1.b_valid, 1'b0);
    check("rst_a_dout_l1",  bus1.a_dout,  '0);
    check("rst_b_dout_l1",  bus1.b_dout,  '0);
    check("rst_ready_l2",   bus2.ready,   1'b0);
    check("rst_b_valid_l2", bus2.b_valid, 1'b0);
    check("rst_a_dout_l2",  bus2.a_dout,  '0);
    check("rst_b_dout_l2",  bus2.b_dout,  '0);
    ready_m = 1'b0;
    clr_m   = 0;
    h1      = '0;
    h2      = '0;
    bd1_m   = '0;
    bd2_m   = '0;
    idle();
    repeat (hold_cycles) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [AW-1:0] ra;
    idle();
    #2;

    // Power-up clear: ready low for 16 cycles, then every address reads 0.
    do_reset(3);
    repeat (DEPTH - 1) tick();
    check("clr_ready_low", bus1.ready, 1'b0);
    tick();
    check("clr_ready_high", bus1.ready, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b0, '0, '0, 1'b1, 1'b0, AW'(i), '0);
      tick();
      check("clr_rd_valid", bus1.b_valid, 1'b1);
      check("clr_rd_data",  bus1.b_dout,  8'h00);
    end
    idle();
    tick();

    // Load then read back.
    set_in(1'b0, '0, '0, 1'b1, 1'b1, 4'd0, 8'h1F);
    tick();
    check("ld_wr_no_valid", bus1.b_valid, 1'b0);
    set_in(1'b0, '0, '0, 1'b1, 1'b1, 4'd15, 8'h0F);
    tick();
    set_in(1'b0, '0, '0, 1'b1, 1'b0, 4'd0, '0);
    tick();
    check("ld_rd0_l1", bus1.b_dout, 8'h1F);
    set_in(1'b0, '0, '0, 1'b1, 1'b0, 4'd15, '0);
    tick();
    check("ld_rd15_l1", bus1.b_dout, 8'h0F);
    check("ld_rd0_l2",  bus2.b_dout, 8'h1F);
    idle();
    tick();
    check("ld_rd15_l2", bus2.b_dout, 8'h0F);
    tick();
    check("ld_hold_l1", bus1.b_dout, 8'h0F);

    // Same-address write collision: port A wins.
    set_in(1'b1, 4'd3, 8'hAA, 1'b1, 1'b1, 4'd3, 8'h55);
    tick();
    set_in(1'b0, '0, '0, 1'b1, 1'b0, 4'd3, '0);
    tick();
    check("coll_l1", bus1.b_dout, 8'hAA);
    idle();
    tick();
    check("coll_l2", bus2.b_dout, 8'hAA);

    // Read-first: B reads old data while A overwrites the same word.
    set_in(1'b0, '0, '0, 1'b1, 1'b1, 4'd5, 8'h90);
    tick();
    set_in(1'b1, 4'd5, 8'h77, 1'b1, 1'b0, 4'd5, '0);
    tick();
    check("rf_old_l1", bus1.b_dout, 8'h90);
    check("rf_a_old_l1", bus1.a_dout, 8'h90);
    set_in(1'b0, 4'd5, '0, 1'b1, 1'b0, 4'd5, '0);
    tick();
    check("rf_old_l2", bus2.b_dout, 8'h90);
    check("rf_new_l1", bus1.b_dout, 8'h77);
    idle();
    tick();
    check("rf_new_l2", bus2.b_dout, 8'h77);

    // Back-to-back reads: latency 2 gives three consecutive strobes in order.
    set_in(1'b0, '0, '0, 1'b1, 1'b1, 4'd0, 8'h11);
    tick();
    set_in(1'b0, '0, '0, 1'b1, 1'b1, 4'd1, 8'h22);
    tick();
    set_in(1'b0, '0, '0, 1'b1, 1'b1, 4'd2, 8'h33);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, '0, '0, 1'b1, 1'b0, AW'(i), '0);
      tick();
      check("b2b_first_l2_quiet", bus2.b_valid, (i == 0) ? 1'b0 : 1'b1);
    end
    idle();
    tick();
    check("b2b_last_valid_l2", bus2.b_valid, 1'b1);
    check("b2b_last_data_l2",  bus2.b_dout,  8'h33);
    tick();
    check("b2b_done_l2", bus2.b_valid, 1'b0);

    // Randomized traffic with frequent same-address pairs.
    for (int n = 0; n < 400; n++) begin
      ra = AW'($urandom_range(0, DEPTH - 1));
      set_in(1'($urandom_range(0, 1)), ra, DW'($urandom),
             1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 2) == 0) ? ra : AW'($urandom_range(0, DEPTH - 1)),
             DW'($urandom));
      tick();
    end

    // Reads pending at reset are dropped.
    set_in(1'b0, '0, '0, 1'b1, 1'b0, 4'd2, '0);
    tick();
    do_reset(2);

    // Reset mid-clear: abort at clear cycle 7, then a full restart.
    repeat (7) tick();
    do_reset(2);
    repeat (DEPTH - 1) tick();
    check("mid_ready_low", bus1.ready, 1'b0);
    tick();
    check("mid_ready_high", bus1.ready, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b0, '0, '0, 1'b1, 1'b0, AW'(i), '0);
      tick();
      check("mid_rd_data", bus1.b_dout, 8'h00);
    end
    idle();
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
